// File: rtl/bp_cce_inst_fetch.sv
// rtl/bp_cce_inst_fetch.sv - CCE microcode fetch: instruction RAM, PC, stall replay, mispredict redirect, config load port
module bp_cce_inst_fetch #(
  parameter int inst_ram_els_p = 256,
  parameter int inst_width_p = 48,
  localparam int pc_width_p = $clog2(inst_ram_els_p)
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic                    mode_normal_i,
  input  logic                    cfg_v_i,
  input  logic                    cfg_w_i,
  input  logic [pc_width_p-1:0]   cfg_addr_i,
  input  logic [inst_width_p-1:0] cfg_data_i,
  output logic                    cfg_ready_o,
  output logic [inst_width_p-1:0] cfg_data_o,
  output logic                    cfg_data_v_o,
  input  logic                    stall_i,
  input  logic                    mispredict_i,
  input  logic [pc_width_p-1:0]   branch_target_i,
  output logic [inst_width_p-1:0] inst_o,
  output logic                    inst_v_o,
  output logic [pc_width_p-1:0]   pc_o
);

  localparam logic [1:0] e_init        = 2'd0;
  localparam logic [1:0] e_fetch_start = 2'd1;
  localparam logic [1:0] e_fetch       = 2'd2;

  logic [1:0]              rst_sync_r;
  logic                    rst_n;
  logic [1:0]              state_r;
  logic                    inst_v_r;
  logic                    cfg_data_v_r;
  logic [pc_width_p-1:0]   pc_r;
  logic [pc_width_p-1:0]   fetch_pc_r;
  logic [inst_width_p-1:0] ram_data_r;
  logic [inst_width_p-1:0] mem [inst_ram_els_p];

  logic                    ram_en;
  logic                    ram_we;
  logic [pc_width_p-1:0]   ram_addr;
  logic                    stall_eff;
  logic                    redirect;

  // Reset asserts immediately but is released only after two clean clock edges
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) rst_sync_r <= 2'b00;
    else            rst_sync_r <= {rst_sync_r[0], 1'b1};
  end
  assign rst_n = rst_sync_r[1];

  // A bubble cycle carries no instruction, so stall and mispredict are meaningless there
  assign stall_eff = stall_i & inst_v_r;
  assign redirect  = mispredict_i & inst_v_r;

  always_comb begin
    ram_en   = 1'b0;
    ram_we   = 1'b0;
    ram_addr = fetch_pc_r;
    case (state_r)
      e_init: begin
        if (cfg_v_i) begin
          ram_addr = cfg_addr_i;
          ram_we   = cfg_w_i;
          ram_en   = ~cfg_w_i;
        end
      end
      e_fetch_start: begin
        ram_en   = 1'b1;
        ram_addr = '0;
      end
      e_fetch: begin
        // Holding the read register on stall replays the current word unchanged
        if (!stall_eff) begin
          ram_en = 1'b1;
          if (redirect) ram_addr = branch_target_i;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (ram_we) mem[ram_addr] <= cfg_data_i;
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= e_init;
      inst_v_r     <= 1'b0;
      cfg_data_v_r <= 1'b0;
      pc_r         <= '0;
      fetch_pc_r   <= '0;
      ram_data_r   <= '0;
    end else begin
      if (ram_en) ram_data_r <= mem[ram_addr];
      cfg_data_v_r <= (state_r == e_init) & cfg_v_i & ~cfg_w_i;
      case (state_r)
        e_init: begin
          inst_v_r <= 1'b0;
          if (mode_normal_i && !cfg_v_i) state_r <= e_fetch_start;
        end
        e_fetch_start: begin
          state_r    <= e_fetch;
          inst_v_r   <= 1'b1;
          pc_r       <= '0;
          fetch_pc_r <= pc_width_p'(1);
        end
        e_fetch: begin
          if (!stall_eff) begin
            if (!mode_normal_i) begin
              state_r    <= e_init;
              inst_v_r   <= 1'b0;
              pc_r       <= '0;
              fetch_pc_r <= '0;
            end else if (redirect) begin
              // The target is fetched again in the bubble cycle and presented after it
              inst_v_r   <= 1'b0;
              fetch_pc_r <= branch_target_i;
            end else begin
              inst_v_r   <= 1'b1;
              pc_r       <= fetch_pc_r;
              fetch_pc_r <= fetch_pc_r + pc_width_p'(1);
            end
          end
        end
        default: state_r <= e_init;
      endcase
    end
  end

  assign cfg_ready_o  = (state_r == e_init);
  assign cfg_data_o   = ram_data_r;
  assign cfg_data_v_o = cfg_data_v_r;
  assign inst_o       = ram_data_r;
  assign inst_v_o     = inst_v_r;
  assign pc_o         = pc_r;

endmodule

// File: tb/tb_bp_cce_inst_fetch.sv
// tb/tb_bp_cce_inst_fetch.sv - self-checking bench for bp_cce_inst_fetch
module tb_bp_cce_inst_fetch;

  logic        clk_i = 1'b0;
  logic        reset_n_i = 1'b0;
  logic        mode_normal_i = 1'b0;
  logic        cfg_v_i = 1'b0;
  logic        cfg_w_i = 1'b0;
  logic [7:0]  cfg_addr_i = '0;
  logic [47:0] cfg_data_i = '0;
  logic        cfg_ready_o;
  logic [47:0] cfg_data_o;
  logic        cfg_data_v_o;
  logic        stall_i = 1'b0;
  logic        mispredict_i = 1'b0;
  logic [7:0]  branch_target_i = '0;
  logic [47:0] inst_o;
  logic        inst_v_o;
  logic [7:0]  pc_o;

  int checks = 0;
  int failures = 0;

  bp_cce_inst_fetch dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .mode_normal_i(mode_normal_i),
    .cfg_v_i(cfg_v_i), .cfg_w_i(cfg_w_i), .cfg_addr_i(cfg_addr_i), .cfg_data_i(cfg_data_i),
    .cfg_ready_o(cfg_ready_o), .cfg_data_o(cfg_data_o), .cfg_data_v_o(cfg_data_v_o),
    .stall_i(stall_i), .mispredict_i(mispredict_i), .branch_target_i(branch_target_i),
    .inst_o(inst_o), .inst_v_o(inst_v_o), .pc_o(pc_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic       st;
    logic       mp;
    logic [7:0] tgt;
    logic       mode;
    logic       ev;
    logic       erdy;
    logic [7:0] epc;
  } vec_t;

  typedef struct {
    logic       v;
    logic       rdy;
    logic [7:0] pc;
  } exp_t;

  vec_t        tbl[22];
  logic [47:0] cfg_q[$];
  exp_t        fetch_q[$];

  function automatic logic [47:0] word_of(input int a);
    logic [7:0]  aa;
    logic [15:0] mix;
    aa  = a[7:0];
    mix = 16'({8'h00, aa} * 16'd257 + 16'd3);
    return {8'hA5, aa, ~aa, mix, aa ^ 8'h3C};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic step();
    logic [47:0] e;
    @(posedge clk_i);
    #1;
    if (cfg_data_v_o) begin
      if (cfg_q.size() == 0) begin
        chk("cfg_data_v_unexpected", 64'(cfg_data_v_o), 64'd0);
      end else begin
        e = cfg_q.pop_front();
        chk("cfg_data", 64'(cfg_data_o), 64'(e));
      end
    end
  endtask

  task automatic cfg_write(input logic [7:0] a, input logic [47:0] d);
    cfg_v_i = 1'b1; cfg_w_i = 1'b1; cfg_addr_i = a; cfg_data_i = d;
    step();
    cfg_v_i = 1'b0; cfg_w_i = 1'b0;
  endtask

  task automatic cfg_read(input logic [7:0] a, input logic [47:0] exp_d);
    cfg_v_i = 1'b1; cfg_w_i = 1'b0; cfg_addr_i = a;
    cfg_q.push_back(exp_d);
    step();
    chk($sformatf("cfg_data_v_after_read_%0h", a), 64'(cfg_data_v_o), 64'd1);
    cfg_v_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1);
  end

  initial begin
    exp_t e;
    tbl[0]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00};
    tbl[1]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00};
    tbl[2]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h01};
    tbl[3]  = '{1'b1, 1'b1, 8'h40, 1'b1, 1'b1, 1'b0, 8'h01};
    tbl[4]  = '{1'b0, 1'b1, 8'h40, 1'b1, 1'b0, 1'b0, 8'h00};
    tbl[5]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h40};
    tbl[6]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h41};
    tbl[7]  = '{1'b0, 1'b1, 8'h01, 1'b1, 1'b0, 1'b0, 8'h00};
    tbl[8]  = '{1'b1, 1'b1, 8'h80, 1'b1, 1'b1, 1'b0, 8'h01};
    tbl[9]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h02};
    tbl[10] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h02};
    tbl[11] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h02};
    tbl[12] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h02};
    tbl[13] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h03};
    tbl[14] = '{1'b0, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, 8'h00};
    tbl[15] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'hFF};
    tbl[16] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00};
    tbl[17] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h01};
    tbl[18] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h01};
    tbl[19] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h01};
    tbl[20] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00};
    tbl[21] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00};

    // Reset values
    repeat (3) step();
    chk("reset_inst_v", 64'(inst_v_o), 64'd0);
    chk("reset_pc", 64'(pc_o), 64'd0);
    chk("reset_inst", 64'(inst_o), 64'd0);
    chk("reset_cfg_data_v", 64'(cfg_data_v_o), 64'd0);
    reset_n_i = 1'b1;
    repeat (3) step();
    chk("init_cfg_ready", 64'(cfg_ready_o), 64'd1);

    // Config load and readback
    cfg_write(8'd0, 48'h1111);
    cfg_write(8'd1, 48'h2222);
    cfg_read(8'd1, 48'h2222);
    step();
    chk("cfg_data_v_one_cycle", 64'(cfg_data_v_o), 64'd0);

    for (int a = 0; a < 256; a++) cfg_write(8'(a), word_of(a));
    cfg_read(8'd0, word_of(0));
    cfg_read(8'd3, word_of(3));
    cfg_read(8'd255, word_of(255));
    step();
    chk("cfg_data_v_drop", 64'(cfg_data_v_o), 64'd0);

    // Fetch table: sequential, stall, mispredict, bubble, wrap, mode exit
    for (int i = 0; i < 22; i++) begin
      stall_i = tbl[i].st;
      mispredict_i = tbl[i].mp;
      branch_target_i = tbl[i].tgt;
      mode_normal_i = tbl[i].mode;
      fetch_q.push_back('{tbl[i].ev, tbl[i].erdy, tbl[i].epc});
      step();
      e = fetch_q.pop_front();
      chk($sformatf("row%0d_inst_v", i), 64'(inst_v_o), 64'(e.v));
      chk($sformatf("row%0d_cfg_ready", i), 64'(cfg_ready_o), 64'(e.rdy));
      if (e.v || e.rdy) chk($sformatf("row%0d_pc", i), 64'(pc_o), 64'(e.pc));
      if (e.v) chk($sformatf("row%0d_inst", i), 64'(inst_o), 64'(word_of(int'(e.pc))));
    end
    stall_i = 1'b0; mispredict_i = 1'b0;

    // Asynchronous reset in the middle of fetch
    mode_normal_i = 1'b1;
    repeat (3) step();
    chk("pre_reset_inst_v", 64'(inst_v_o), 64'd1);
    chk("pre_reset_pc", 64'(pc_o), 64'd1);
    #3;
    reset_n_i = 1'b0;
    #1;
    chk("async_reset_inst_v", 64'(inst_v_o), 64'd0);
    chk("async_reset_pc", 64'(pc_o), 64'd0);
    chk("async_reset_inst", 64'(inst_o), 64'd0);
    mode_normal_i = 1'b0;
    step();
    reset_n_i = 1'b1;
    repeat (3) step();
    chk("post_reset_cfg_ready", 64'(cfg_ready_o), 64'd1);
    chk("post_reset_inst_v", 64'(inst_v_o), 64'd0);

    // Reset drops a pending config read response
    cfg_read(8'd5, word_of(5));
    #3;
    reset_n_i = 1'b0;
    #1;
    chk("reset_drops_cfg_data_v", 64'(cfg_data_v_o), 64'd0);
    step();
    reset_n_i = 1'b1;
    repeat (3) step();
    chk("cfg_queue_drained", 64'(cfg_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
